lcd_frame_sequencer: RTL and testbench

- Sequences the parallel character LCD controller (clplcd) so that a 2x16 character frame can be refreshed from a local 32-byte buffer with one start pulse.
- Performs the LCD power-up reset once after system reset, then on request issues display-clear, or the refresh sequence: address 0x00, 16 data writes, address 0x40, 16 data writes.
- Sits between application logic (sensor readout and formatting) and the LCD controller's level-request / done-flag interface.

---
 rtl/lcd_frame_sequencer_if.sv | 41 ++++
 rtl/lcd_frame_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_sequencer_if.sv
// Application-side and LCD-controller-side signals of the frame sequencer.
interface lcd_frame_sequencer_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          clr;
  logic          busy;
  logic          done;
  logic          err;
  logic          initlcd;
  logic          resetlcd;
  logic          clearlcd;
  logic          homelcd;
  logic          datalcd;
  logic          addrlcd;
  logic          cmdlcd;
  logic [DW-1:0] lcddatin;
  logic          lcdreset;
  logic          lcdclear;
  logic          lcdhome;
  logic          lcddata;
  logic          lcdaddr;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, clr,
    input  lcdreset, lcdclear, lcdhome, lcddata, lcdaddr,
    output busy, done, err, initlcd,
    output resetlcd, clearlcd, homelcd, datalcd, addrlcd, cmdlcd, lcddatin
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, clr,
    output lcdreset, lcdclear, lcdhome, lcddata, lcdaddr,
    input  busy, done, err, initlcd,
    input  resetlcd, clearlcd, homelcd, datalcd, addrlcd, cmdlcd, lcddatin
  );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// Drives the clplcd controller: power-up reset, display clear, or a full
// 2x16 frame refresh from a local 32-byte character buffer.
module lcd_frame_sequencer #(
  parameter logic [23:0] TIMEOUT    = 24'd4194304,
  parameter logic [6:0]  LINE2_ADDR = 7'h40
) (
  input logic                  CLK,
  input logic                  RST,
  lcd_frame_sequencer_if.slave bus
);
  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 5;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned STEP_W = 6;
  localparam int unsigned CNT_W  = 24;
  localparam logic [STEP_W-1:0] LINE2_STEP = 6'd17;
  localparam logic [STEP_W-1:0] LAST_STEP  = 6'd33;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_REQ, S_NEXT, S_ERR} state_t;
  typedef enum logic [1:0] {OP_RESET, OP_CLEAR, OP_ADDR, OP_DATA} op_t;
  typedef enum logic [1:0] {JOB_POWERUP, JOB_CLEAR, JOB_REFRESH} job_t;

  logic [DW-1:0]     buf_q [DEPTH];
  state_t            state_q;
  op_t               op_q;
  job_t              job_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_start_q;
  logic              pend_clr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              initlcd_q;
  logic              resetlcd_q;
  logic              clearlcd_q;
  logic              addrlcd_q;
  logic              datalcd_q;
  logic [DW-1:0]     lcddatin_q;

  logic [STEP_W-1:0] step_d;
  logic [AW-1:0]     byte_idx_d;
  op_t               nxt_op_d;
  logic [DW-1:0]     nxt_dat_d;
  logic              ack_d;
  logic              want_start_d;
  logic              want_clr_d;
  logic              dispatch_d;

  // Operand of the following refresh step; reads the buffer before a same-edge write lands.
  always_comb begin
    step_d     = step_q + STEP_W'(1);
    byte_idx_d = (step_d > LINE2_STEP) ? AW'(step_d - STEP_W'(2)) : AW'(step_d - STEP_W'(1));
    nxt_op_d   = OP_DATA;
    nxt_dat_d  = buf_q[byte_idx_d];
    if (step_d == LINE2_STEP) begin
      nxt_op_d  = OP_ADDR;
      nxt_dat_d = {1'b0, LINE2_ADDR};
    end
  end

  always_comb begin
    ack_d = 1'b0;
    case (op_q)
      OP_RESET: ack_d = bus.lcdreset;
      OP_CLEAR: ack_d = bus.lcdclear;
      OP_ADDR:  ack_d = bus.lcdaddr;
      OP_DATA:  ack_d = bus.lcddata;
      default:  ack_d = 1'b0;
    endcase
  end

  // Work is picked up from idle, or straight after a finished clear/refresh.
  always_comb begin
    want_start_d = pend_start_q | bus.start;
    want_clr_d   = pend_clr_q | bus.clr;
    dispatch_d   = (state_q == S_IDLE) ||
                   ((state_q == S_NEXT) && (job_q != JOB_POWERUP) &&
                    ((job_q == JOB_CLEAR) || (step_q == LAST_STEP)));
  end

  always_ff @(posedge CLK) begin
    if (bus.wr_en) buf_q[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_INIT;
      op_q         <= OP_RESET;
      job_q        <= JOB_POWERUP;
      step_q       <= '0;
      cnt_q        <= '0;
      pend_start_q <= 1'b0;
      pend_clr_q   <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      initlcd_q    <= 1'b0;
      resetlcd_q   <= 1'b0;
      clearlcd_q   <= 1'b0;
      addrlcd_q    <= 1'b0;
      datalcd_q    <= 1'b0;
      lcddatin_q   <= '0;
    end else begin
      done_q       <= 1'b0;
      initlcd_q    <= 1'b0;
      pend_start_q <= want_start_d;
      pend_clr_q   <= want_clr_d;
      case (state_q)
        S_IDLE: busy_q <= 1'b0;
        S_INIT: begin
          // Straight out of reset the init pulse has not been issued yet.
          if (!initlcd_q) begin
            initlcd_q <= 1'b1;
          end else begin
            state_q    <= S_REQ;
            cnt_q      <= '0;
            resetlcd_q <= (op_q == OP_RESET);
            clearlcd_q <= (op_q == OP_CLEAR);
            addrlcd_q  <= (op_q == OP_ADDR);
            datalcd_q  <= (op_q == OP_DATA);
          end
        end
        S_REQ: begin
          if (ack_d) begin
            state_q    <= S_NEXT;
            resetlcd_q <= 1'b0;
            clearlcd_q <= 1'b0;
            addrlcd_q  <= 1'b0;
            datalcd_q  <= 1'b0;
          end else if (cnt_q == TIMEOUT - CNT_W'(1)) begin
            state_q      <= S_ERR;
            err_q        <= 1'b1;
            pend_start_q <= 1'b0;
            pend_clr_q   <= 1'b0;
            resetlcd_q   <= 1'b0;
            clearlcd_q   <= 1'b0;
            addrlcd_q    <= 1'b0;
            datalcd_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (job_q == JOB_POWERUP) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if ((job_q == JOB_REFRESH) && (step_q != LAST_STEP)) begin
            state_q    <= S_INIT;
            step_q     <= step_d;
            op_q       <= nxt_op_d;
            lcddatin_q <= nxt_dat_d;
            initlcd_q  <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_ERR: begin
          if (bus.start || bus.clr) begin
            state_q    <= S_INIT;
            err_q      <= 1'b0;
            job_q      <= JOB_POWERUP;
            op_q       <= OP_RESET;
            lcddatin_q <= '0;
            initlcd_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A clear always goes ahead of a refresh that is wanted at the same time.
      if (dispatch_d) begin
        if (want_clr_d) begin
          state_q    <= S_INIT;
          job_q      <= JOB_CLEAR;
          op_q       <= OP_CLEAR;
          lcddatin_q <= '0;
          initlcd_q  <= 1'b1;
          busy_q     <= 1'b1;
          pend_clr_q <= 1'b0;
        end else if (want_start_d) begin
          state_q      <= S_INIT;
          job_q        <= JOB_REFRESH;
          op_q         <= OP_ADDR;
          step_q       <= '0;
          lcddatin_q   <= '0;
          initlcd_q    <= 1'b1;
          busy_q       <= 1'b1;
          pend_start_q <= 1'b0;
        end else begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.initlcd  = initlcd_q;
  assign bus.resetlcd = resetlcd_q;
  assign bus.clearlcd = clearlcd_q;
  assign bus.addrlcd  = addrlcd_q;
  assign bus.datalcd  = datalcd_q;
  assign bus.homelcd  = 1'b0;
  assign bus.cmdlcd   = 1'b0;
  assign bus.lcddatin = lcddatin_q;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Frame sequencer bench: a clplcd-like responder plus an operation-list model.
module tb_lcd_frame_sequencer;
  localparam logic [23:0] TMO = 24'd100;
  localparam int OP_RESET = 0, OP_CLEAR = 1, OP_ADDR = 2, OP_DATA = 3, OP_DONE = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  lcd_frame_sequencer_if bus ();

  lcd_frame_sequencer #(.TIMEOUT(TMO), .LINE2_ADDR(7'h40)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cmp_cnt = 0, err_cnt = 0;
  logic [7:0] mbuf [32];
  int log_op[$], log_dat[$], exp_op[$], exp_dat[$];
  int init_cnt = 0, done_cnt = 0, viol_cnt = 0, busy_low_cnt = 0;
  int req_len = 0, last_req_len = 0, rsp_cnt = 0;
  int lat_reset = 50, lat_data = 2;
  bit hang_data = 1'b0;
  logic [3:0] prev_req = 4'b0;
  logic [7:0] held_dat = 8'h00;
  int lb, ib, db;

  // Controller responder and operation monitor, both sampling on the falling edge.
  always @(negedge CLK) begin
    logic [3:0] mreq;
    mreq = {bus.resetlcd, bus.clearlcd, bus.addrlcd, bus.datalcd};
    if (mreq == 4'b0) begin
      rsp_cnt = 0;
      bus.lcdreset = 1'b0; bus.lcdclear = 1'b0; bus.lcdaddr = 1'b0; bus.lcddata = 1'b0;
    end else begin
      rsp_cnt++;
      if (bus.resetlcd && rsp_cnt > lat_reset) bus.lcdreset = 1'b1;
      if (bus.clearlcd && rsp_cnt > lat_data) bus.lcdclear = 1'b1;
      if (bus.addrlcd && rsp_cnt > lat_data) bus.lcdaddr = 1'b1;
      if (bus.datalcd && !hang_data && rsp_cnt > lat_data) bus.lcddata = 1'b1;
    end
    bus.lcdhome = 1'b0;
    if (bus.initlcd === 1'b1) init_cnt++;
    if (bus.done === 1'b1) begin done_cnt++; log_op.push_back(OP_DONE); log_dat.push_back(0); end
    if (bus.busy === 1'b0 && bus.done !== 1'b1) busy_low_cnt++;
    if (bus.cmdlcd !== 1'b0 || bus.homelcd !== 1'b0 || (bus.initlcd === 1'b1 && mreq != 4'b0)) viol_cnt++;
    if (mreq != 4'b0 && prev_req == 4'b0) begin
      if (!$onehot(mreq)) viol_cnt++;
      log_op.push_back(mreq[3] ? OP_RESET : mreq[2] ? OP_CLEAR : mreq[1] ? OP_ADDR : OP_DATA);
      log_dat.push_back(int'(bus.lcddatin));
      held_dat = bus.lcddatin;
      req_len = 1;
    end else if (mreq != 4'b0) begin
      if (bus.lcddatin !== held_dat || mreq != prev_req) viol_cnt++;
      req_len++;
    end else if (prev_req != 4'b0) begin
      last_req_len = req_len;
    end
    prev_req = mreq;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    mbuf[a] = d;
  endtask

  task automatic pulse(input bit s, input bit c);
    bus.start = s; bus.clr = c;
    tick();
    bus.start = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic mark();
    lb = log_op.size(); ib = init_cnt; db = done_cnt;
    exp_op.delete(); exp_dat.delete();
  endtask

  task automatic exp_push(input int op, input int d);
    exp_op.push_back(op); exp_dat.push_back(d);
  endtask

  task automatic exp_refresh();
    exp_push(OP_ADDR, 8'h00);
    for (int i = 0; i < 16; i++) exp_push(OP_DATA, int'(mbuf[i]));
    exp_push(OP_ADDR, 8'h40);
    for (int i = 16; i < 32; i++) exp_push(OP_DATA, int'(mbuf[i]));
    exp_push(OP_DONE, 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin tick(); n++; end
    cmp_cnt++;
    if (bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, bus.busy, budget);
    end
    @(negedge CLK); #1;
  endtask

  task automatic wait_done(input string name, input int count, input int budget);
    int n = 0;
    while (done_cnt - db < count && n < budget) begin tick(); n++; end
    cmp_cnt++;
    if (done_cnt - db < count) begin
      err_cnt++;
      $display("FAIL %s_done_wait: %0d done pulses after %0d cycles, required %0d", name, done_cnt - db, budget, count);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    mark();
    cmp_cnt++;
    if ({bus.busy, bus.done, bus.err, bus.initlcd, bus.resetlcd, bus.clearlcd, bus.addrlcd,
         bus.datalcd, bus.homelcd, bus.cmdlcd} !== 10'b1000000000 || bus.lcddatin !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_values: busy=%b done=%b err=%b init=%b req=%b%b%b%b dat=%h, required busy=1 rest 0",
               bus.busy, bus.done, bus.err, bus.initlcd, bus.resetlcd, bus.clearlcd, bus.addrlcd, bus.datalcd, bus.lcddatin);
    end
    RST = 1'b0;
    wait_idle("powerup", 400);
    exp_push(OP_RESET, 0);
    cmp_cnt++;
    if (init_cnt - ib !== 1) begin err_cnt++; $display("FAIL powerup_init: %0d pulses, required 1", init_cnt - ib); end
    cmp_cnt++;
    if (last_req_len !== 51) begin err_cnt++; $display("FAIL powerup_reqlen: %0d cycles, required 51", last_req_len); end
    cmp_cnt++;
    if (done_cnt - db !== 0) begin err_cnt++; $display("FAIL powerup_done: %0d pulses, required 0", done_cnt - db); end
    cmp_cnt++;
    if (log_op.size() - lb !== 1 || log_op[lb] !== OP_RESET) begin
      err_cnt++; $display("FAIL powerup_ops: %0d ops logged, required a single RESET", log_op.size() - lb);
    end
  endtask

  task automatic test_refresh(input string name, input bit rand_buf);
    string s1 = "ABCDEFGHIJKLMNOP", s2 = "0123456789abcdef";
    for (int i = 0; i < 32; i++)
      write_byte(i, rand_buf ? 8'($urandom) : (i < 16 ? s1[i] : s2[i-16]));
    lat_data = rand_buf ? int'($urandom_range(0, 4)) : 1;
    mark();
    exp_refresh();
    pulse(1'b1, 1'b0);
    wait_idle(name, 1000);
    cmp_cnt++;
    if (log_op.size() - lb !== exp_op.size()) begin
      err_cnt++; $display("FAIL %s_len: %0d ops, required %0d", name, log_op.size() - lb, exp_op.size());
    end
    for (int i = 0; i < exp_op.size() && lb + i < log_op.size(); i++) begin
      cmp_cnt++;
      if (log_op[lb+i] !== exp_op[i] || log_dat[lb+i] !== exp_dat[i]) begin
        err_cnt++;
        $display("FAIL %s_op[%0d]: got op %0d data %h, required op %0d data %h", name, i, log_op[lb+i], log_dat[lb+i], exp_op[i], exp_dat[i]);
      end
    end
    cmp_cnt++;
    if (init_cnt - ib !== 34 || done_cnt - db !== 1) begin
      err_cnt++; $display("FAIL %s_counts: init=%0d done=%0d, required 34 and 1", name, init_cnt - ib, done_cnt - db);
    end
  endtask

  task automatic test_both();
    lat_data = int'($urandom_range(0, 3));
    mark();
    exp_push(OP_CLEAR, 0); exp_push(OP_DONE, 0);
    exp_refresh();
    pulse(1'b1, 1'b1);
    busy_low_cnt = 0;
    wait_done("both", 2, 1500);
    cmp_cnt++;
    if (busy_low_cnt !== 0) begin err_cnt++; $display("FAIL both_busy: busy low %0d cycles, required 0", busy_low_cnt); end
    wait_idle("both", 10);
    cmp_cnt++;
    if (log_op.size() - lb !== exp_op.size()) begin
      err_cnt++; $display("FAIL both_len: %0d ops, required %0d", log_op.size() - lb, exp_op.size());
    end
    for (int i = 0; i < exp_op.size() && lb + i < log_op.size(); i++) begin
      cmp_cnt++;
      if (log_op[lb+i] !== exp_op[i] || log_dat[lb+i] !== exp_dat[i]) begin
        err_cnt++;
        $display("FAIL both_op[%0d]: got op %0d data %h, required op %0d data %h", i, log_op[lb+i], log_dat[lb+i], exp_op[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_pending();
    lat_data = 2;
    mark();
    exp_refresh(); exp_refresh();
    pulse(1'b1, 1'b0);
    repeat (20) tick();
    pulse(1'b1, 1'b0);
    repeat (20) tick();
    pulse(1'b1, 1'b0);
    wait_idle("pending", 2000);
    cmp_cnt++;
    if (log_op.size() - lb !== exp_op.size() || init_cnt - ib !== 68 || done_cnt - db !== 2) begin
      err_cnt++;
      $display("FAIL pending_counts: ops=%0d init=%0d done=%0d, required %0d, 68, 2", log_op.size() - lb, init_cnt - ib, done_cnt - db, exp_op.size());
    end
    for (int i = 0; i < exp_op.size() && lb + i < log_op.size(); i++) begin
      cmp_cnt++;
      if (log_op[lb+i] !== exp_op[i] || log_dat[lb+i] !== exp_dat[i]) begin
        err_cnt++;
        $display("FAIL pending_op[%0d]: got op %0d data %h, required op %0d data %h", i, log_op[lb+i], log_dat[lb+i], exp_op[i], exp_dat[i]);
      end
    end
  endtask

  // Byte 5 is sampled when the 7th operation of the refresh enters its init cycle.
  task automatic test_write_race();
    int L = 2;
    lat_data = L;
    for (int b = 1; b >= 0; b--) begin
      logic [7:0] nv;
      int n = 0, g = 0;
      write_byte(5, 8'h11);
      nv = 8'(8'h20 + $urandom_range(0, 8'h5e));
      mark();
      pulse(1'b1, 1'b0);
      while (g < 500) begin
        if (bus.initlcd === 1'b1) n++;
        if (n == 6) break;
        tick(); g++;
      end
      repeat (L + 2 - b) tick();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = nv;
      tick();
      bus.wr_en = 1'b0;
      wait_idle("race", 1000);
      cmp_cnt++;
      if (log_op.size() - lb !== 35 || log_dat[lb+6] !== int'(b ? nv : 8'h11)) begin
        err_cnt++;
        $display("FAIL race_%s: ops=%0d byte5=%h, required 35 ops byte5=%h", b ? "before" : "at",
                 log_op.size() - lb, (log_op.size() > lb + 6) ? log_dat[lb+6] : -1, b ? nv : 8'h11);
      end
      mbuf[5] = nv;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    lat_data = 1;
    hang_data = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (30) tick();
    pulse(1'b1, 1'b0);
    while (bus.err !== 1'b1 && n < 1000) begin tick(); n++; end
    cmp_cnt++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1 ||
        {bus.resetlcd, bus.clearlcd, bus.addrlcd, bus.datalcd} !== 4'b0) begin
      err_cnt++;
      $display("FAIL timeout_flag: err=%b busy=%b req=%b%b%b%b, required err=1 busy=1 req=0000",
               bus.err, bus.busy, bus.resetlcd, bus.clearlcd, bus.addrlcd, bus.datalcd);
    end
    @(negedge CLK); #1;
    cmp_cnt++;
    if (last_req_len !== int'(TMO)) begin err_cnt++; $display("FAIL timeout_len: %0d cycles in request, required %0d", last_req_len, TMO); end
    hang_data = 1'b0;
    repeat (5) tick();
    cmp_cnt++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin err_cnt++; $display("FAIL timeout_sticky: err=%b busy=%b, required 1 1", bus.err, bus.busy); end
    mark();
    exp_push(OP_RESET, 0); exp_push(OP_CLEAR, 0); exp_push(OP_DONE, 0);
    pulse(1'b0, 1'b1);
    cmp_cnt++;
    if (bus.err !== 1'b0) begin err_cnt++; $display("FAIL timeout_clear: err=%b, required 0", bus.err); end
    wait_done("recover", 1, 800);
    wait_idle("recover", 50);
    cmp_cnt++;
    if (log_op.size() - lb !== 3) begin err_cnt++; $display("FAIL recover_len: %0d ops, required 3", log_op.size() - lb); end
    for (int i = 0; i < 3 && lb + i < log_op.size(); i++) begin
      cmp_cnt++;
      if (log_op[lb+i] !== exp_op[i]) begin
        err_cnt++; $display("FAIL recover_op[%0d]: got op %0d, required op %0d", i, log_op[lb+i], exp_op[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    lat_data = 2;
    pulse(1'b1, 1'b0);
    repeat (30) tick();
    RST = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.busy !== 1'b1 || bus.initlcd !== 1'b0 || bus.lcddatin !== 8'h00 ||
        {bus.resetlcd, bus.clearlcd, bus.addrlcd, bus.datalcd} !== 4'b0) begin
      err_cnt++;
      $display("FAIL rst_async: busy=%b init=%b dat=%h req=%b%b%b%b, required busy=1 rest 0",
               bus.busy, bus.initlcd, bus.lcddatin, bus.resetlcd, bus.clearlcd, bus.addrlcd, bus.datalcd);
    end
    tick(); tick();
    mark();
    RST = 1'b0;
    wait_idle("rst_mid", 400);
    cmp_cnt++;
    if (log_op.size() - lb !== 1 || log_op[log_op.size()-1] !== OP_RESET || done_cnt - db !== 0 || last_req_len !== 51) begin
      err_cnt++;
      $display("FAIL rst_mid_powerup: ops=%0d done=%0d reqlen=%0d, required one RESET, 0 done, 51 cycles",
               log_op.size() - lb, done_cnt - db, last_req_len);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.clr = 1'b0;
    test_reset();
    test_refresh("refresh", 1'b0);
    for (int k = 0; k < 3; k++) test_refresh("rand_refresh", 1'b1);
    test_both();
    test_pending();
    test_write_race();
    test_timeout();
    test_rst_mid();
    cmp_cnt++;
    if (viol_cnt !== 0) begin err_cnt++; $display("FAIL protocol: %0d handshake violations, required 0", viol_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
